// File: rtl/mont_stream_loader.sv
// Feed/drain stage for the montgomery core: gathers A, B and M from a 32-bit
// stream, launches the core, then streams the 381-bit result back out.
module mont_stream_loader #(
  parameter int N     = 381,
  parameter int DW    = 32,
  parameter int WORDS = 12
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic [DW-1:0] s_data,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic          reuse_m,
  output logic [DW-1:0] m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          mont_start,
  output logic [N-1:0]  mont_a,
  output logic [N-1:0]  mont_b,
  output logic [N-1:0]  mont_m,
  input  logic [N-1:0]  mont_result,
  input  logic          mont_done,
  output logic          busy
);

  localparam int SW = WORDS * DW;
  localparam int LW = N - (WORDS - 1) * DW;
  localparam logic [3:0] LAST = 4'(WORDS - 1);

  typedef enum logic [2:0] {LOAD_A, LOAD_B, LOAD_M, START, WAIT, DRAIN} state_t;

  state_t        state, state_next;
  logic [3:0]    wcnt;
  logic [SW-1:0] shift;
  logic          in_xfer, out_xfer, last;

  assign in_xfer  = s_valid & s_ready;
  assign out_xfer = m_valid & m_ready;
  assign last     = (wcnt == LAST);
  assign m_data   = shift[DW-1:0];
  assign busy     = (state != LOAD_A) || (wcnt != 4'd0);

  // The top word only carries the bits that exist in the N-bit operand.
  function automatic logic [N-1:0] put_word(input logic [N-1:0] op,
                                            input logic [3:0]   idx,
                                            input logic [DW-1:0] w);
    logic [N-1:0] r;
    r = op;
    for (int k = 0; k < WORDS - 1; k++)
      if (idx == 4'(k)) r[k*DW +: DW] = w;
    if (idx == LAST) r[N-1 -: LW] = w[LW-1:0];
    return r;
  endfunction

  always_comb begin
    state_next = state;
    case (state)
      LOAD_A:  if (in_xfer && last) state_next = LOAD_B;
      LOAD_B:  if (in_xfer && last) state_next = reuse_m ? START : LOAD_M;
      LOAD_M:  if (in_xfer && last) state_next = START;
      START:   state_next = WAIT;
      WAIT:    if (mont_done) state_next = DRAIN;
      DRAIN:   if (out_xfer && last) state_next = LOAD_A;
      default: state_next = LOAD_A;
    endcase
  end

  // Handshake flags are registered copies of the next-state decode, so they
  // never depend combinationally on s_valid or m_ready.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= LOAD_A;
      s_ready    <= 1'b0;
      m_valid    <= 1'b0;
      mont_start <= 1'b0;
    end else begin
      state      <= state_next;
      s_ready    <= (state_next == LOAD_A) || (state_next == LOAD_B) ||
                    (state_next == LOAD_M);
      m_valid    <= (state_next == DRAIN);
      mont_start <= (state_next == START);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      wcnt <= 4'd0;
    else if (in_xfer || out_xfer)
      wcnt <= last ? 4'd0 : wcnt + 4'd1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mont_a <= '0;
      mont_b <= '0;
      mont_m <= '0;
    end else if (in_xfer) begin
      case (state)
        LOAD_A:  mont_a <= put_word(mont_a, wcnt, s_data);
        LOAD_B:  mont_b <= put_word(mont_b, wcnt, s_data);
        LOAD_M:  mont_m <= put_word(mont_m, wcnt, s_data);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      shift <= '0;
    else if (state == WAIT && mont_done)
      shift <= SW'(mont_result);
    else if (out_xfer)
      shift <= shift >> DW;
  end

endmodule

// File: tb/tb_mont_stream_loader.sv
// Bench for mont_stream_loader: a bit-serial Montgomery model stands in for the
// core and produces the expected result words for every job sent.
module tb_mont_stream_loader;

  localparam int N = 381;
  localparam int DW = 32;
  localparam int WORDS = 12;
  localparam logic [383:0] P384 =
    384'h1a0111ea397fe69a4b1ba7b6434bacd764774b84f38512bf6730d2a0f6b0f6241eabfffeb153ffffb9feffffffffaaab;

  logic          clk = 1'b0;
  logic          resetn;
  logic [DW-1:0] s_data;
  logic          s_valid, s_ready, reuse_m;
  logic [DW-1:0] m_data;
  logic          m_valid, m_ready, mont_start, mont_done, busy;
  logic [N-1:0]  mont_a, mont_b, mont_m, mont_result;
  logic          core_done, spur_done;
  logic [N-1:0]  core_result, spur_result;

  assign mont_done   = core_done | spur_done;
  assign mont_result = spur_done ? spur_result : core_result;

  mont_stream_loader #(.N(N), .DW(DW), .WORDS(WORDS)) dut (
    .clk(clk), .resetn(resetn),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .reuse_m(reuse_m),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .mont_start(mont_start), .mont_a(mont_a), .mont_b(mont_b), .mont_m(mont_m),
    .mont_result(mont_result), .mont_done(mont_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails = 0;
  int start_count = 0;
  int jobs = 0;
  int out_count = 0;
  int core_lat = 8;
  bit gaps = 0;
  logic [31:0]  exp_q[$];
  logic [N-1:0] m_last;
  logic [N-1:0] P;

  task automatic checkOutput(input string name, input logic [383:0] actual,
                             input logic [383:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // A*B*2^-381 mod M, bit-serial over A.
  function automatic logic [N-1:0] montmul(input logic [N-1:0] a,
                                           input logic [N-1:0] b,
                                           input logic [N-1:0] m);
    logic [383:0] t;
    t = '0;
    for (int i = 0; i < N; i++) begin
      if (a[i]) t = t + {3'b0, b};
      if (t[0]) t = t + {3'b0, m};
      t = t >> 1;
    end
    if (t >= {3'b0, m}) t = t - {3'b0, m};
    return t[N-1:0];
  endfunction

  task automatic pushExpected(input logic [N-1:0] res);
    logic [383:0] r;
    r = {3'b0, res};
    for (int k = 0; k < WORDS; k++) exp_q.push_back(r[k*DW +: DW]);
  endtask

  task automatic sendWord(input logic [31:0] w);
    int guard;
    logic rdy;
    guard = 0;
    if (gaps && $urandom_range(0, 2) == 0) begin
      s_valid = 1'b0;
      s_data  = $urandom;
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end
    s_data  = w;
    s_valid = 1'b1;
    do begin
      @(negedge clk);
      rdy = s_ready;
      @(posedge clk);
      #1;
      guard++;
    end while (!rdy && guard < 50);
    if (!rdy) checkOutput("s_ready_timeout", 384'(rdy), 384'd1);
    s_valid = 1'b0;
  endtask

  task automatic sendOperand(input logic [383:0] op);
    for (int k = 0; k < WORDS; k++) sendWord(op[k*DW +: DW]);
  endtask

  // reuse_m is driven with noise on every word except the last B word.
  task automatic applyStimulus(input logic [383:0] a, input logic [383:0] b,
                               input logic [383:0] m, input bit reuse, input bit spur);
    reuse_m = 1'b1;
    sendOperand(a);
    checkOutput("busy_in_load_b", 384'(busy), 384'd1);
    for (int k = 0; k < WORDS; k++) begin
      reuse_m = (k == WORDS - 1) ? reuse : ~reuse;
      if (spur && k == 5) begin
        spur_result = '1;
        spur_done   = 1'b1;
      end
      sendWord(b[k*DW +: DW]);
      spur_done = 1'b0;
      if (spur && k == 5) begin
        checkOutput("spur_load_b_s_ready", 384'(s_ready), 384'd1);
        checkOutput("spur_load_b_m_valid", 384'(m_valid), 384'd0);
      end
    end
    reuse_m = 1'b0;
    if (!reuse) begin
      sendOperand(m);
      m_last = m[N-1:0];
    end
    checkOutput("start_pulse", 384'(mont_start), 384'd1);
    checkOutput("start_s_ready", 384'(s_ready), 384'd0);
    jobs++;
    if (spur) begin
      spur_result = '1;
      spur_done   = 1'b1;
      @(posedge clk);
      #1;
      spur_done = 1'b0;
      checkOutput("spur_start_no_drain", 384'(m_valid), 384'd0);
    end else begin
      @(posedge clk);
      #1;
    end
    checkOutput("start_one_cycle", 384'(mont_start), 384'd0);
    checkOutput("start_count", 384'(start_count), 384'(jobs));
    checkOutput("mont_a_loaded", 384'(mont_a), 384'(a[N-1:0]));
    checkOutput("mont_b_loaded", 384'(mont_b), 384'(b[N-1:0]));
    checkOutput("mont_m_value", 384'(mont_m), 384'(m_last));
    pushExpected(montmul(a[N-1:0], b[N-1:0], m_last));
  endtask

  task automatic waitDrain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 400) begin
      @(posedge clk);
      #1;
      guard++;
    end
    checkOutput("drain_done", 384'(exp_q.size()), 384'd0);
    checkOutput("idle_busy", 384'(busy), 384'd0);
    checkOutput("idle_s_ready", 384'(s_ready), 384'd1);
  endtask

  task automatic waitOutCount(input int target);
    int guard;
    guard = 0;
    while (out_count < target && guard < 400) begin
      @(posedge clk);
      #1;
      guard++;
    end
    checkOutput("out_count_reached", 384'(out_count), 384'(target));
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_m_valid"}, 384'(m_valid), 384'd0);
    checkOutput({tag, "_mont_start"}, 384'(mont_start), 384'd0);
    checkOutput({tag, "_busy"}, 384'(busy), 384'd0);
    checkOutput({tag, "_m_data"}, 384'(m_data), 384'd0);
    checkOutput({tag, "_mont_a"}, 384'(mont_a), 384'd0);
    checkOutput({tag, "_mont_b"}, 384'(mont_b), 384'd0);
    checkOutput({tag, "_mont_m"}, 384'(mont_m), 384'd0);
  endtask

  task automatic resetPulse(input string tag);
    resetn = 1'b0;
    #1;
    exp_q.delete();
    m_last = '0;
    checkResetValues(tag);
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    @(posedge clk);
    #1;
    checkOutput({tag, "_s_ready_after"}, 384'(s_ready), 384'd1);
  endtask

  // Core stand-in: answers each start with the Montgomery product after core_lat cycles.
  initial begin
    core_done   = 1'b0;
    core_result = '0;
    forever begin
      @(negedge clk);
      if (resetn && mont_start) begin
        start_count++;
        repeat (core_lat) @(posedge clk);
        #1;
        core_result = montmul(mont_a, mont_b, mont_m);
        core_done   = 1'b1;
        @(posedge clk);
        #1;
        core_done = 1'b0;
      end
    end
  end

  // Compare process: every presented result word must be the head of the queue.
  always @(negedge clk) begin
    if (resetn && m_valid) begin
      if (exp_q.size() == 0) begin
        checkOutput("m_valid_extra", 384'(m_valid), 384'd0);
      end else begin
        checkOutput("m_data", 384'(m_data), 384'(exp_q[0]));
        if (m_ready) begin
          void'(exp_q.pop_front());
          out_count++;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [383:0] one, two, six, three, topa, ra, rb, pw;
    P = P384[N-1:0];
    pw = 384'd1 << 380;
    one = 384'd1; two = 384'd2; three = 384'd3; six = 384'd6;
    topa = 384'hFFFFFFFF << 352;
    resetn = 1'b1; s_data = '0; s_valid = 1'b0; reuse_m = 1'b0; m_ready = 1'b1;
    spur_done = 1'b0; spur_result = '0; m_last = '0;
    #1 resetn = 1'b0;
    #1 checkResetValues("por");
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    @(posedge clk);
    #1 checkOutput("por_s_ready_after", 384'(s_ready), 384'd1);

    checkOutput("model_pin_one", 384'(montmul(pw[N-1:0], two[N-1:0], P)), 384'd1);
    checkOutput("model_pin_three", 384'(montmul(pw[N-1:0], six[N-1:0], P)), 384'd3);
    checkOutput("model_pin_zero", 384'(montmul('0, three[N-1:0], P)), 384'd0);

    $display("[TB] basic job A=1 B=1 M=p");
    applyStimulus(one, one, P384, 1'b0, 1'b0);
    waitDrain();

    $display("[TB] reuse_m job");
    applyStimulus(pw, six, '0, 1'b1, 1'b0);
    waitDrain();

    $display("[TB] backpressure job");
    ra = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
          $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    rb = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
          $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    rb[383:380] = 4'h0;
    gaps = 1'b1;
    applyStimulus(ra, rb, P384, 1'b0, 1'b0);
    gaps = 1'b0;
    waitOutCount(out_count + 4);
    m_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1 m_ready = 1'b1;
    waitDrain();

    $display("[TB] spurious done job");
    applyStimulus(rb, two, P384, 1'b0, 1'b1);
    waitDrain();

    $display("[TB] top-bit masking job");
    applyStimulus(topa, three, P384, 1'b0, 1'b0);
    checkOutput("mont_a_top_bits", 384'(mont_a[380:352]), 384'h1fffffff);
    waitDrain();

    $display("[TB] reset during WAIT");
    core_lat = 20;
    applyStimulus(ra, rb, P384, 1'b0, 1'b0);
    core_lat = 8;
    repeat (3) @(posedge clk);
    #1 checkOutput("wait_busy", 384'(busy), 384'd1);
    resetPulse("rst_wait");
    applyStimulus(rb, rb, P384, 1'b0, 1'b0);
    waitDrain();

    $display("[TB] reset at drain word 5");
    applyStimulus(ra, six, P384, 1'b0, 1'b0);
    waitOutCount(out_count + 5);
    resetPulse("rst_drain");
    applyStimulus(pw, two, P384, 1'b0, 1'b0);
    waitDrain();

    checkOutput("final_start_count", 384'(start_count), 384'(jobs));
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/mont_stream_loader.md
# mont_stream_loader

Upstream feed/drain stage for the `montgomery` multiplier core. Deserializes 32-bit words from a valid/ready stream into the 381-bit operands A, B and M. It then pulses the core's start, waits for done, and serializes the 381-bit result back out on a 32-bit valid/ready stream. It lets a bus master (DMA/AXI bridge) run back-to-back Montgomery products without holding 381-bit registers itself.

## Interface
Parameters:
- `N`, 381, operand/result width in bits.
- `DW`, 32, stream word width.
- `WORDS`, 12, words per operand, equal to ceil(N/DW).

Ports:
- `clk`  in  1  clock; all logic rising-edge.
- `resetn`  in  1  reset, asynchronous, active-low.
- `s_data`  in  DW  input operand word.
- `s_valid`  in  1  input word valid.
- `s_ready`  out  1  loader accepts a word.
- `reuse_m`  in  1  sampled on acceptance of the last B word; 1 = skip the M load and keep the previous M.
- `m_data`  out  DW  result word.
- `m_valid`  out  1  result word valid.
- `m_ready`  in  1  downstream accepts a result word.
- `mont_start`  out  1  one-cycle start pulse to the core.
- `mont_a`, `mont_b`, `mont_m`  out  N  operands to the core.
- `mont_result`  in  N  core result.
- `mont_done`  in  1  core done.
- `busy`  out  1  high whenever state is not LOAD_A, or word count ≠ 0.

## Operation
States: LOAD_A → LOAD_B → (LOAD_M unless `reuse_m`) → START → WAIT → DRAIN → LOAD_A.

Word handling:
- Transfer occurs on `s_valid & s_ready`; likewise on `m_valid & m_ready`.
- 4-bit word counter `wcnt` runs 0..WORDS-1 within each LOAD/DRAIN state, then returns to 0.
- Word order is least-significant first: word k fills bits [32k+31:32k].
- For word 11, only `s_data[28:0]` is used (bits 380:352). `s_data[31:29]` is ignored.

State behaviour:
- LOAD_A, LOAD_B, LOAD_M: `s_ready`=1. When the 12th word is accepted, advance.
- `reuse_m` is sampled only in the cycle the 12th B word is accepted. If 1: LOAD_B → START, and `mont_m` keeps its last loaded value (0 after reset).
- START: `mont_start`=1 for exactly this one cycle; `s_ready`=0.
- WAIT: `s_ready`=0. On `mont_done`=1, capture `mont_result` into a 384-bit shift register (bits 383:381 = 0), go to DRAIN.
- DRAIN: `m_valid`=1, `m_data`=shift[31:0]. Each transfer shifts right by 32. After the 12th transfer, go to LOAD_A.
- Word 11 output = {3'b0, result[380:352]}.

Operand stability and ignored inputs:
- `mont_a`/`mont_b`/`mont_m` are not written from START through the end of DRAIN, so they are stable for the entire core run.
- `mont_done` is ignored in every state except WAIT.
- `s_valid` is ignored outside the LOAD states; no word is lost or buffered.
- `m_ready` is ignored outside DRAIN.

Outputs:
- `s_ready`, `m_valid`, `mont_start` and `busy` are decoded from registered state; there is no combinational path from `s_valid`/`m_ready`.

Reset (asynchronous, any state including mid-WAIT or mid-DRAIN):
- State = LOAD_A, `wcnt`=0.
- `mont_a`/`mont_b`/`mont_m`, shift register and `m_data` = 0.
- `m_valid`=0, `mont_start`=0, `busy`=0.
- `s_ready`=1 from the first edge after `resetn` rises.
- Any partial load or undrained result is discarded.

## Timing
- Load phase: minimum 36 cycles (24 with `reuse_m`) at full input rate.
- START: 1 cycle after the last accepted load word.
- Earliest DRAIN entry: cycle after `mont_done` is seen in WAIT. `m_valid` rises that cycle.
- Drain phase: minimum 12 cycles.
- Loader overhead per job: 1 (START) + 1 (done capture).
- First A word of the next job is accepted the cycle after the 12th result word transfers.

## Test plan
- Basic job: A=1, B=1, M=BLS12-381 p (0x1a0111ea…aaab), core model returns A·B·R⁻¹ mod M.
  - Required: 36 accepted words, one `mont_start` pulse, 12 output words matching the model LS-first, word 11 bits [31:29]=0.
- reuse_m: job 1 with M=p; job 2 sends A,B only with `reuse_m`=1.
  - Required: START one cycle after the 24th word, `mont_m` still = p, result correct.
- Backpressure: random `s_valid` gaps and `m_ready` held low 5 cycles mid-drain.
  - Required: `m_data` stable while stalled, no dropped or duplicated words.
- Spurious done: `mont_done`=1 during LOAD_B and in the START cycle.
  - Required: no state change and no capture; capture happens only on the later WAIT done.
- Reset mid-operation: `resetn` low during WAIT, and separately at DRAIN word 5.
  - Required: outputs immediately at reset values; next full job completes correctly.
- Top-bit masking: word 11 of A = 0xFFFFFFFF.
  - Required: `mont_a[380:352]` = all ones, bits beyond 380 absent.
